// File: rtl/diff_locator_pkg.sv
// Shared types and helpers for the iterative first-difference locator:
// FSM state encoding, scan-direction constants and a chunk popcount.
package diff_locator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic DIR_LSB = 1'b0;
  localparam logic DIR_MSB = 1'b1;

  // Widest chunk the popcount helper handles; narrower chunks are zero-extended.
  localparam int POP_MAX_W = 64;

  function automatic int unsigned chunk_popcount(input logic [POP_MAX_W-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < POP_MAX_W; i++) begin
      n += 32'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/diff_chunk_penc.sv
// Combinational CHUNK-bit priority encoder with selectable direction.
// dir_i = DIR_LSB reports the lowest set bit, DIR_MSB the highest.
module diff_chunk_penc
  import diff_locator_pkg::*;
#(
  parameter int CHUNK = 8,
  localparam int POS_W = (CHUNK > 1) ? $clog2(CHUNK) : 1
) (
  input  logic [CHUNK-1:0] data_i,
  input  logic             dir_i,
  output logic             hit_o,
  output logic [POS_W-1:0] pos_o
);

  // Priority select: the last matching assignment in each loop wins.
  always_comb begin
    hit_o = |data_i;
    pos_o = '0;
    if (dir_i == DIR_LSB) begin
      for (int i = CHUNK - 1; i >= 0; i--) begin
        if (data_i[i]) pos_o = POS_W'(i);
      end
    end else begin
      for (int i = 0; i < CHUNK; i++) begin
        if (data_i[i]) pos_o = POS_W'(i);
      end
    end
  end

endmodule

// File: rtl/diff_locator_seq.sv
// Iterative locator of the first differing bit between two operands.
// Scans in1^in2 one CHUNK per clock in the requested direction and
// returns the bit index plus an equal flag over valid/ready handshakes.
// Optional feature macro DIFF_COUNT_EN: adds out_count (Hamming distance)
// and disables early exit so every request scans all chunks.
module diff_locator_seq
  import diff_locator_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             msb_first,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_equal
`ifdef DIFF_COUNT_EN
  ,
  output logic [IDX_W:0]   out_count
`endif
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int POS_W  = (CHUNK > 1) ? $clog2(CHUNK) : 1;
  localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(NCHUNK - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   xor_q;
  logic               dir_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [IDX_W-1:0]   idx_q;
  logic               equal_q;

  logic [CNT_W-1:0]   chunk_num;
  logic [IDX_W-1:0]   chunk_base;
  logic [WIDTH-1:0]   xor_shifted;
  logic [CHUNK-1:0]   chunk;
  logic               hit;
  logic [POS_W-1:0]   pos;
  logic [IDX_W-1:0]   cand_idx;
  logic               last_chunk;
  logic               accept;

  assign accept     = in_valid && (state_q == IDLE);
  assign last_chunk = (cnt_q == LAST_CHUNK);

  // MSB-first scanning walks the chunk numbers downward from the top chunk.
  assign chunk_num   = (dir_q == DIR_MSB) ? (LAST_CHUNK - cnt_q) : cnt_q;
  assign chunk_base  = IDX_W'(chunk_num) * IDX_W'(CHUNK);
  assign xor_shifted = xor_q >> chunk_base;
  assign chunk       = xor_shifted[CHUNK-1:0];
  assign cand_idx    = chunk_base + IDX_W'(pos);

  diff_chunk_penc #(
    .CHUNK (CHUNK)
  ) u_penc (
    .data_i (chunk),
    .dir_i  (dir_q),
    .hit_o  (hit),
    .pos_o  (pos)
  );

`ifdef DIFF_COUNT_EN
  logic [IDX_W:0] count_q;
  logic [IDX_W:0] chunk_pop;
  logic           found_q;

  assign chunk_pop = (IDX_W + 1)'(chunk_popcount(POP_MAX_W'(chunk)));
  assign out_count = count_q;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: accept in IDLE, walk chunks in SCAN, hold in DONE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (in_valid) state_d = SCAN;
`ifdef DIFF_COUNT_EN
      SCAN: if (last_chunk) state_d = DONE;
`else
      SCAN: if (hit || last_chunk) state_d = DONE;
`endif
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded straight from the state register.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  // Datapath: latch operands on accept, record the result while scanning.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xor_q   <= '0;
      dir_q   <= DIR_LSB;
      cnt_q   <= '0;
      idx_q   <= '0;
      equal_q <= 1'b0;
`ifdef DIFF_COUNT_EN
      count_q <= '0;
      found_q <= 1'b0;
`endif
    end else if (accept) begin
      xor_q   <= in1 ^ in2;
      dir_q   <= msb_first;
      cnt_q   <= '0;
`ifdef DIFF_COUNT_EN
      count_q <= '0;
      found_q <= 1'b0;
`endif
    end else if (state_q == SCAN) begin
`ifdef DIFF_COUNT_EN
      count_q <= count_q + chunk_pop;
      if (hit && !found_q) begin
        found_q <= 1'b1;
        idx_q   <= cand_idx;
      end
      if (last_chunk) begin
        equal_q <= !found_q && !hit;
        if (!found_q && !hit) idx_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
`else
      if (hit) begin
        idx_q   <= cand_idx;
        equal_q <= 1'b0;
      end else if (last_chunk) begin
        idx_q   <= '0;
        equal_q <= 1'b1;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
`endif
    end
  end

  assign out_idx   = idx_q;
  assign out_equal = equal_q;

endmodule
